// File: rtl/rx_pkg.sv
// Shared types and elaboration helpers for the serial receive sequencer.
package rx_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_CHK  = 3'd1,
        DATA       = 3'd2,
        PARITY_CHK = 3'd3,
        STOP_CHK   = 3'd4,
        LOAD       = 3'd5,
        WAIT_IDLE  = 3'd6
    } rx_state_t;

    function automatic int rx_half(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

    function automatic int rx_idx_w(input int num_data_bits);
        return $clog2(num_data_bits + 1);
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period counter: ticks after HALF cycles when half_sel is set, otherwise
// every CLKS_PER_BIT cycles; a clear restarts the interval.
module rx_bit_timer
    import rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int CNT_BITS     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_half_sel,
    output logic o_tick
);

    localparam logic [CNT_BITS-1:0] C_FULL = CNT_BITS'(CLKS_PER_BIT);
    localparam logic [CNT_BITS-1:0] C_HALF = CNT_BITS'(rx_half(CLKS_PER_BIT));

    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_target;

    assign w_target = i_half_sel ? C_HALF : C_FULL;
    assign o_tick   = i_enable && !i_clear && (r_cnt == w_target);

    // The counter restarts at 1 so the cycle after a clear is count 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= CNT_BITS'(1);
        end else if (i_enable) begin
            if (o_tick) begin
                r_cnt <= CNT_BITS'(1);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_sequencer.sv
// Receive-path control FSM: start detect, bit-centre strobes, stop check.
// Optional parity check enabled by defining RX_PARITY_CHK_EN.
module rx_sequencer
    import rx_pkg::*;
#(
    parameter int NUM_DATA_BITS = 8,
    parameter int CLKS_PER_BIT  = 10,
    parameter int CNT_BITS      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 serial_in,
    output logic                                 shift_strobe,
    output logic                                 load_buffer,
    output logic                                 packet_done,
    output logic                                 framing_error,
    output logic                                 parity_error,
    output logic                                 busy,
    output logic [rx_idx_w(NUM_DATA_BITS)-1:0]   bit_index
);

    localparam int IDX_W = rx_idx_w(NUM_DATA_BITS);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_DATA_BITS - 1);

    rx_state_t        r_state;
    rx_state_t        w_next;
    logic             r_prev;
    logic [IDX_W-1:0] r_bit_index;
    logic             r_framing_err;
    logic             w_tick;
    logic             w_clear;
    logic             w_strobe;
    logic             w_clr_err;
    logic             w_set_fe;
`ifdef RX_PARITY_CHK_EN
    logic             r_parity;
    logic             r_parity_err;
    logic             w_set_pe;
`endif

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_BITS     (CNT_BITS)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_enable   (r_state != IDLE),
        .i_half_sel (r_state == START_CHK),
        .o_tick     (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_clear   = 1'b0;
        w_strobe  = 1'b0;
        w_clr_err = 1'b0;
        w_set_fe  = 1'b0;
`ifdef RX_PARITY_CHK_EN
        w_set_pe  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (r_prev && !serial_in) begin
                    w_next  = START_CHK;
                    w_clear = 1'b1;
                end
            end
            START_CHK: begin
                if (w_tick) begin
                    if (!serial_in) begin
                        w_next    = DATA;
                        w_clr_err = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_strobe = 1'b1;
                    if (r_bit_index == C_LAST) begin
`ifdef RX_PARITY_CHK_EN
                        w_next = PARITY_CHK;
`else
                        w_next = STOP_CHK;
`endif
                    end
                end
            end
`ifdef RX_PARITY_CHK_EN
            PARITY_CHK: begin
                if (w_tick) begin
                    w_set_pe = r_parity ^ serial_in;
                    w_next   = STOP_CHK;
                end
            end
`endif
            STOP_CHK: begin
                if (w_tick) begin
                    if (serial_in) begin
                        w_next = LOAD;
                    end else begin
                        w_set_fe = 1'b1;
                        w_next   = WAIT_IDLE;
                    end
                end
            end
            LOAD: begin
                w_next = IDLE;
            end
            WAIT_IDLE: begin
                if (serial_in) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Edge-detect history resets high so a line held low is not a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev        <= 1'b1;
            r_bit_index   <= '0;
            r_framing_err <= 1'b0;
        end else begin
            r_prev <= serial_in;
            if (w_clear) begin
                r_bit_index <= '0;
            end else if (w_strobe) begin
                r_bit_index <= r_bit_index + 1'b1;
            end
            if (w_clr_err) begin
                r_framing_err <= 1'b0;
            end else if (w_set_fe) begin
                r_framing_err <= 1'b1;
            end
        end
    end

`ifdef RX_PARITY_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity     <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_clr_err) begin
                r_parity     <= 1'b0;
                r_parity_err <= 1'b0;
            end else begin
                if (w_strobe) begin
                    r_parity <= r_parity ^ serial_in;
                end
                if (w_set_pe) begin
                    r_parity_err <= 1'b1;
                end
            end
        end
    end

    assign parity_error = r_parity_err;
`else
    assign parity_error = 1'b0;
`endif

    assign shift_strobe  = w_strobe;
    assign load_buffer   = (r_state == LOAD);
    assign packet_done   = (r_state == LOAD);
    assign busy          = (r_state != IDLE);
    assign framing_error = r_framing_err;
    assign bit_index     = r_bit_index;

endmodule
